fetch_ram_rd_ctrl: RTL
======================

FETCH_RAM_RD_CTRL -- requirements
Module: fetch_ram_rd_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WD, default 8, read-address width.
REQ-002 SHALL have parameter DATA_WD, default `PIXEL_WIDTH*8 (64), read-data width.
REQ-003 SHALL have parameter RAM_DEPTH, default 208, number of valid buffer words.
REQ-004 SHALL have port: clk  in  1  single clock, rising edge.
REQ-005 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port: start_i  in  1  one-cycle request pulse.
REQ-007 SHALL have port: base_addr_i  in  ADDR_WD  first word address, sampled on accepted start.
REQ-008 SHALL have port: len_i  in  ADDR_WD  word count, sampled on accepted start.
REQ-009 SHALL have port: busy_o  out  1  high from accepted start until done.
REQ-010 SHALL have port: done_o  out  1  one-cycle completion pulse.
REQ-011 SHALL have port: ram_re_o  out  1  RAM read enable, high active.
REQ-012 SHALL have port: ram_addr_o  out  ADDR_WD  RAM read address.
REQ-013 SHALL have port: ram_data_i  in  DATA_WD  RAM read data, valid one cycle after ram_re_o.
REQ-014 SHALL have port: dat_valid_o  out  1  output beat valid.
REQ-015 SHALL have port: dat_ready_i  in  1  consumer ready.
REQ-016 SHALL have port: dat_o  out  DATA_WD  output beat data.
REQ-017 SHALL have port: dat_last_o  out  1  marks final beat of request.

Function
REQ-018 SHALL implement FSM IDLE -> READ -> DRAIN -> IDLE.
REQ-019 IDLE: start_i with len_i>0 SHALL go to READ; start_i with len_i=0 SHALL pulse done_o next cycle, no RAM read.
REQ-020 start_i while busy_o=1 SHALL be ignored.
REQ-021 READ: SHALL issue ram_re_o only when issued-but-unaccepted beats (in flight plus buffered) < 2.
REQ-022 Read address SHALL start at base_addr_i and increment by 1 per issued read.
REQ-023 READ SHALL go to DRAIN in the cycle after the len-th read is issued.
REQ-024 Returned data SHALL be captured into a 2-entry skid FIFO; RAM read latency fixed at 1 cycle.
REQ-025 Output SHALL follow valid/ready: beat transfers when dat_valid_o & dat_ready_i; dat_o and dat_last_o SHALL be held stable while valid & ~ready.
REQ-026 Beats SHALL emerge in address order, no drop, no duplicate; dat_last_o high only on beat len.
REQ-027 DRAIN: on transfer of last beat SHALL pulse done_o next cycle, deassert busy_o, return to IDLE.
REQ-028 Minimum latency start_i -> first dat_valid_o SHALL be 2 cycles; with dat_ready_i held high, throughput SHALL be 1 beat/cycle.
REQ-029 ram_re_o SHALL be 0 whenever the FSM is IDLE or DRAIN; ram_addr_o SHALL hold its last value when ram_re_o=0.

Reset
REQ-030 rst high SHALL asynchronously force IDLE, empty FIFO, and busy_o, done_o, ram_re_o, dat_valid_o, dat_last_o = 0, ram_addr_o = 0, dat_o = 0.
REQ-031 rst asserted mid-request SHALL abandon the request; no done_o pulse SHALL follow.

Configuration
REQ-032 With FETCH_RD_WRAP_EN defined, the read address SHALL wrap from RAM_DEPTH-1 (207) to 0 (circular buffer).
REQ-033 Without FETCH_RD_WRAP_EN, the address SHALL wrap modulo 2^ADDR_WD (255 -> 0); addresses 208..255 are the caller's responsibility.

Structure
REQ-034 FSM state encodings and the FIFO depth constant (2) SHALL live in the shared defines file beside `PIXEL_WIDTH.
REQ-035 The 2-entry skid FIFO SHALL be a sub-module named fetch_rd_skid_fifo.

Verification
REQ-036 base=0x10, len=4, ready=1 -> ram_addr_o 0x10..0x13 on consecutive cycles; 4 beats in order; dat_last_o on beat 4; one done_o pulse.
REQ-037 base=0x05, len=6, ready toggling 1/0 every cycle -> 6 beats, order intact, no more than 2 reads outstanding, data stable during stalls.
REQ-038 With FETCH_RD_WRAP_EN: base=206 (0xCE), len=4 -> addresses 206, 207, 0, 1; without macro -> 206, 207, 208, 209.
REQ-039 len=0 start -> done_o one cycle later; ram_re_o and dat_valid_o never asserted.
REQ-040 rst asserted after beat 2 of len=8 -> all outputs 0 immediately, no done_o; a new start base=0, len=2 then completes normally.
REQ-041 start_i pulsed again during busy -> ignored; original request completes with its own len.

Source files
------------

// File: rtl/fetch_ram_rd_ctrl_pkg.sv
// Shared types and constants for the fetch RAM read controller: pixel width,
// FSM encodings and skid FIFO depth.
`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 8
`endif

package fetch_ram_rd_ctrl_pkg;

  localparam int PIXEL_WIDTH = `PIXEL_WIDTH;

  localparam int FIFO_DEPTH  = 2;
  localparam int FIFO_CNT_WD = $clog2(FIFO_DEPTH + 1);
  localparam int FIFO_PTR_WD = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_rd_skid_fifo.sv
// Two-entry skid FIFO for RAM read returns; an incoming word bypasses storage
// when the FIFO is empty and the consumer is ready.
module fetch_rd_skid_fifo
  import fetch_ram_rd_ctrl_pkg::*;
#(
  parameter int DATA_WD = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [DATA_WD-1:0]     in_data,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [DATA_WD-1:0]     out_data,
  output logic [FIFO_CNT_WD-1:0] count
);

  logic [DATA_WD-1:0]     mem [FIFO_DEPTH];
  logic [FIFO_PTR_WD-1:0] wr_ptr;
  logic [FIFO_PTR_WD-1:0] rd_ptr;
  logic                   empty;
  logic                   push;
  logic                   pop;

  always_comb begin
    empty     = (count == '0);
    out_valid = ~empty | in_valid;
    if (!empty)
      out_data = mem[rd_ptr];
    else if (in_valid)
      out_data = in_data;
    else
      out_data = '0;
    pop  = out_ready & ~empty;
    // Stored only when the word cannot leave through the bypass this cycle.
    push = in_valid & ~(empty & out_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_ram_rd_ctrl.sv
// Fetch RAM read controller: streams len words from base_addr out over valid/ready.
// FETCH_RD_WRAP_EN makes the read address wrap at RAM_DEPTH instead of 2^ADDR_WD.
//
// state    | meaning
// ST_IDLE  | waiting for start_i
// ST_READ  | issuing RAM reads, at most FIFO_DEPTH words unaccepted
// ST_DRAIN | all reads issued, waiting for the last beat to transfer
module fetch_ram_rd_ctrl
  import fetch_ram_rd_ctrl_pkg::*;
#(
  parameter int ADDR_WD   = 8,
  parameter int DATA_WD   = PIXEL_WIDTH * 8,
  parameter int RAM_DEPTH = 208
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [ADDR_WD-1:0] base_addr_i,
  input  logic [ADDR_WD-1:0] len_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               ram_re_o,
  output logic [ADDR_WD-1:0] ram_addr_o,
  input  logic [DATA_WD-1:0] ram_data_i,
  output logic               dat_valid_o,
  input  logic               dat_ready_i,
  output logic [DATA_WD-1:0] dat_o,
  output logic               dat_last_o
);

  localparam int IF_WD = FIFO_CNT_WD + 1;

  fetch_state_e state;
  fetch_state_e state_nxt;

  logic [ADDR_WD-1:0]     nxt_addr_q;
  logic [ADDR_WD-1:0]     addr_q;
  logic [ADDR_WD-1:0]     rd_left_q;
  logic [ADDR_WD-1:0]     beat_left_q;
  logic                   rd_pend_q;
  logic [FIFO_CNT_WD-1:0] fifo_cnt;
  logic [IF_WD-1:0]       inflight;
  logic                   xfer;
  logic                   load;
  logic                   done_set;

  function automatic logic [ADDR_WD-1:0] addr_inc(input logic [ADDR_WD-1:0] a);
`ifdef FETCH_RD_WRAP_EN
    addr_inc = (a == ADDR_WD'(RAM_DEPTH - 1)) ? '0 : a + 1'b1;
`else
    addr_inc = a + 1'b1;
`endif
  endfunction

  fetch_rd_skid_fifo #(
    .DATA_WD (DATA_WD)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_pend_q),
    .in_data   (ram_data_i),
    .out_ready (dat_ready_i),
    .out_valid (dat_valid_o),
    .out_data  (dat_o),
    .count     (fifo_cnt)
  );

  assign xfer       = dat_valid_o & dat_ready_i;
  assign dat_last_o = dat_valid_o & (beat_left_q == ADDR_WD'(1));
  // A beat accepted this cycle frees its slot immediately, keeping 1 beat/cycle.
  assign inflight   = IF_WD'(fifo_cnt) + IF_WD'(rd_pend_q) - IF_WD'(xfer);
  assign ram_addr_o = ram_re_o ? nxt_addr_q : addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:
        if (start_i && (len_i != '0))
          state_nxt = ST_READ;
      ST_READ:
        if (ram_re_o && (rd_left_q == ADDR_WD'(1)))
          state_nxt = ST_DRAIN;
      ST_DRAIN:
        if (xfer && (beat_left_q == ADDR_WD'(1)))
          state_nxt = ST_IDLE;
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o   = (state != ST_IDLE);
    ram_re_o = (state == ST_READ) && (inflight < IF_WD'(FIFO_DEPTH));
    load     = (state == ST_IDLE) && start_i && (len_i != '0);
    done_set = ((state == ST_IDLE) && start_i && (len_i == '0)) ||
               ((state == ST_DRAIN) && xfer && (beat_left_q == ADDR_WD'(1)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nxt_addr_q  <= '0;
      addr_q      <= '0;
      rd_left_q   <= '0;
      beat_left_q <= '0;
      rd_pend_q   <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      rd_pend_q <= ram_re_o;
      done_o    <= done_set;
      if (load) begin
        nxt_addr_q  <= base_addr_i;
        rd_left_q   <= len_i;
        beat_left_q <= len_i;
      end else begin
        if (ram_re_o) begin
          addr_q     <= nxt_addr_q;
          nxt_addr_q <= addr_inc(nxt_addr_q);
          rd_left_q  <= rd_left_q - 1'b1;
        end
        if (xfer)
          beat_left_q <= beat_left_q - 1'b1;
      end
    end
  end

endmodule
